// File: rtl/pc_core.sv
// pc_core: RV32I program-counter register with combinational PC+4, previous PC and update counter.
// Define PC_ALIGN_CHECK_EN to force word alignment of loaded PCs and raise a sticky misalignment flag.
module pc_core #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XLEN-1:0]  i_pc_next,
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_pc_plus4,
  output logic [XLEN-1:0]  o_pc_prev,
  output logic [CNT_W-1:0] o_upd_cnt,
  output logic             o_misalign_err
);

  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_prev_q;
  logic [CNT_W-1:0] upd_cnt_q;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_err_q, misalign_err_d;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    pc_d           = i_pc_next;
    misalign_err_d = misalign_err_q;
    if (i_pc_next[1:0] != 2'b00) begin
      pc_d           = {i_pc_next[XLEN-1:2], 2'b00};
      misalign_err_d = 1'b1;
    end
  end

  assign o_misalign_err = misalign_err_q;
`else
  always_comb begin
    pc_d = i_pc_next;
  end

  assign o_misalign_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q           <= RESET_VECTOR;
      pc_prev_q      <= RESET_VECTOR;
      upd_cnt_q      <= '0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_err_q <= 1'b0;
`endif
    end else begin
      pc_q           <= pc_d;
      pc_prev_q      <= pc_q;
      upd_cnt_q      <= upd_cnt_q + CNT_STEP;
`ifdef PC_ALIGN_CHECK_EN
      misalign_err_q <= misalign_err_d;
`endif
    end
  end

  // Wraps modulo 2^XLEN by virtue of the XLEN-bit sum.
  assign o_pc_plus4 = pc_q + PC_STEP;
  assign o_pc       = pc_q;
  assign o_pc_prev  = pc_prev_q;
  assign o_upd_cnt  = upd_cnt_q;

endmodule

// File: tb/tb_pc_core.sv
// tb_pc_core: randomized self-checking bench for pc_core against a behavioural PC model.
// Expectations follow PC_ALIGN_CHECK_EN when the bench is built with that macro.
module tb_pc_core;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic [31:0] pc, pc_plus4, pc_prev, upd_cnt;
  logic        misalign_err;
  logic [31:0] s_pc, s_pc_plus4, s_pc_prev;
  logic [3:0]  s_upd_cnt;
  logic        s_misalign_err;

  int total;
  int bad;

  // Behavioural model state
  logic [31:0] m_pc, m_prev;
  int unsigned m_cnt;
  bit          m_err;

  pc_core dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc_next(pc_next),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_pc_prev(pc_prev),
    .o_upd_cnt(upd_cnt), .o_misalign_err(misalign_err)
  );

  // Narrow counter instance makes the counter wrap reachable in a short run.
  pc_core #(.CNT_W(4)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc_next(pc_next),
    .o_pc(s_pc), .o_pc_plus4(s_pc_plus4), .o_pc_prev(s_pc_prev),
    .o_upd_cnt(s_upd_cnt), .o_misalign_err(s_misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc   = 32'h0;
    m_prev = 32'h0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  // Advance one edge with the given next-PC, updating the model from the spec rules.
  task automatic step(input logic [31:0] nxt);
    pc_next = nxt;
    @(posedge clk);
    if (rst_n) begin
      m_prev = m_pc;
      if (ALIGN && (nxt % 4) != 0) begin
        m_pc  = nxt - (nxt % 4);
        m_err = 1'b1;
      end else begin
        m_pc = nxt;
      end
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pc_next = 32'h40;
    model_reset();
    #1;
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc_no_edge: got %h required %h", pc, 32'h0); end
    for (int i = 0; i < 3; i++) begin
      step(32'h40);
      total++;
      if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc[%0d]: got %h required %h", i, pc, 32'h0); end
      total++;
      if (pc_prev !== 32'h0) begin bad++; $display("FAIL reset_prev[%0d]: got %h required %h", i, pc_prev, 32'h0); end
      total++;
      if (upd_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt[%0d]: got %0d required 0", i, upd_cnt); end
      total++;
      if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b required 0", i, misalign_err); end
    end
    total++;
    if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_plus4: got %h required %h", pc_plus4, 32'h4); end
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(m_pc + 32'd4);
      total++;
      if (pc !== 32'(4 * (k + 1))) begin bad++; $display("FAIL seq_pc[%0d]: got %h required %h", k, pc, 32'(4 * (k + 1))); end
      total++;
      if (pc_prev !== 32'(4 * k)) begin bad++; $display("FAIL seq_prev[%0d]: got %h required %h", k, pc_prev, 32'(4 * k)); end
      total++;
      if (upd_cnt !== 32'(k + 1)) begin bad++; $display("FAIL seq_cnt[%0d]: got %0d required %0d", k, upd_cnt, k + 1); end
    end
  endtask

  task automatic test_async_reset();
    total++;
    if (pc !== 32'h14) begin bad++; $display("FAIL async_pre_pc: got %h required %h", pc, 32'h14); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL async_pc: got %h required %h", pc, 32'h0); end
    total++;
    if (pc_prev !== 32'h0) begin bad++; $display("FAIL async_prev: got %h required %h", pc_prev, 32'h0); end
    total++;
    if (upd_cnt !== 32'h0) begin bad++; $display("FAIL async_cnt: got %0d required 0", upd_cnt); end
    #1;
    rst_n = 1'b1;
    step(32'h80);
    total++;
    if (pc !== 32'h80) begin bad++; $display("FAIL async_release_pc: got %h required %h", pc, 32'h80); end
    total++;
    if (pc_prev !== 32'h0) begin bad++; $display("FAIL async_release_prev: got %h required %h", pc_prev, 32'h0); end
    total++;
    if (upd_cnt !== 32'h1) begin bad++; $display("FAIL async_release_cnt: got %0d required 1", upd_cnt); end
  endtask

  task automatic test_wrap();
    step(32'hFFFF_FFFC);
    total++;
    if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc: got %h required %h", pc, 32'hFFFF_FFFC); end
    total++;
    if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4: got %h required %h", pc_plus4, 32'h0); end
    total++;
    if (misalign_err !== 1'b0) begin bad++; $display("FAIL wrap_err: got %b required 0", misalign_err); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_err;
    exp_pc  = ALIGN ? 32'h100 : 32'h102;
    exp_err = ALIGN;
    step(32'h102);
    total++;
    if (pc !== exp_pc) begin bad++; $display("FAIL misalign_pc: got %h required %h", pc, exp_pc); end
    total++;
    if (misalign_err !== exp_err) begin bad++; $display("FAIL misalign_err: got %b required %b", misalign_err, exp_err); end
    for (int i = 0; i < 3; i++) begin
      step(32'h200 + 32'(4 * i));
      total++;
      if (pc !== 32'h200 + 32'(4 * i)) begin bad++; $display("FAIL misalign_after_pc[%0d]: got %h required %h", i, pc, 32'h200 + 32'(4 * i)); end
      total++;
      if (misalign_err !== exp_err) begin bad++; $display("FAIL misalign_sticky[%0d]: got %b required %b", i, misalign_err, exp_err); end
    end
  endtask

  task automatic test_random();
    logic [31:0] nxt;
    for (int i = 0; i < 60; i++) begin
      nxt = $urandom;
      if ($urandom_range(0, 3) != 0) nxt[1:0] = 2'b00;
      step(nxt);
      total++;
      if (pc !== m_pc) begin bad++; $display("FAIL rand_pc[%0d]: got %h required %h", i, pc, m_pc); end
      total++;
      if (pc_plus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rand_plus4[%0d]: got %h required %h", i, pc_plus4, m_pc + 32'd4); end
      total++;
      if (pc_prev !== m_prev) begin bad++; $display("FAIL rand_prev[%0d]: got %h required %h", i, pc_prev, m_prev); end
      total++;
      if (upd_cnt !== m_cnt) begin bad++; $display("FAIL rand_cnt[%0d]: got %0d required %0d", i, upd_cnt, m_cnt); end
      total++;
      if (misalign_err !== m_err) begin bad++; $display("FAIL rand_err[%0d]: got %b required %b", i, misalign_err, m_err); end
      total++;
      if (s_upd_cnt !== 4'(m_cnt % 16)) begin bad++; $display("FAIL rand_small_cnt[%0d]: got %0d required %0d", i, s_upd_cnt, m_cnt % 16); end
    end
  endtask

  task automatic test_cnt_wrap();
    int guard;
    guard = 0;
    while ((m_cnt % 16) != 15 && guard < 32) begin
      step(m_pc + 32'd4);
      guard++;
    end
    total++;
    if (s_upd_cnt !== 4'hF) begin bad++; $display("FAIL cnt_wrap_pre: got %0d required 15", s_upd_cnt); end
    step(m_pc + 32'd4);
    total++;
    if (s_upd_cnt !== 4'h0) begin bad++; $display("FAIL cnt_wrap: got %0d required 0", s_upd_cnt); end
    total++;
    if (upd_cnt !== m_cnt) begin bad++; $display("FAIL cnt_wide: got %0d required %0d", upd_cnt, m_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sequential();
    test_async_reset();
    test_wrap();
    test_misalign();
    test_random();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
